// File: rtl/lr35902_oam_pkg.sv
// Shared OAM geometry, read fill value and write-source encoding for the banked OAM store.
package lr35902_oam_pkg;

    localparam int         OAM_ENTRIES         = 40;
    localparam int         OAM_BYTES_PER_ENTRY = 4;
    localparam int         OAM_LANES           = 2;
    localparam logic [7:0] OAM_FILL_READ       = 8'hFF;

    function automatic int oam_words(input int entries, input int bpe, input int lanes);
        return (entries * bpe) / lanes;
    endfunction

    function automatic int oam_wadr_w(input int entries, input int bpe, input int lanes);
        return $clog2(oam_words(entries, bpe, lanes));
    endfunction

    typedef enum logic [1:0] {
        WSRC_NONE,
        WSRC_CLEAR,
        WSRC_DMA,
        WSRC_CPU
    } oam_wsrc_t;

endpackage

// File: rtl/lr35902_oam_lane.sv
// One OAM byte bank: single write port, two registered read ports (CPU, PPU), read-first.
// Read data updates one cycle after its read strobe and holds otherwise.
module lr35902_oam_lane
    import lr35902_oam_pkg::*;
#(
    parameter int WORDS  = 80,
    parameter int WADR_W = 7
) (
    input  logic              clk,
    input  logic              we,
    input  logic [WADR_W-1:0] wadr,
    input  logic [7:0]        wdat,
    input  logic              a_rd,
    input  logic [WADR_W-1:0] a_adr,
    output logic [7:0]        a_dat,
    input  logic              b_rd,
    input  logic [WADR_W-1:0] b_adr,
    output logic [7:0]        b_dat
);

    logic [7:0] mem [WORDS];

    // Non-blocking update gives the old word to a same-cycle read.
    always_ff @(posedge clk) begin
        if (we)   mem[wadr] <= wdat;
        if (a_rd) a_dat     <= mem[a_adr];
        if (b_rd) b_dat     <= mem[b_adr];
    end

endmodule

// File: rtl/lr35902_oam_banked.sv
// Banked OAM store: CPU byte port, DMA write port, LANES-wide PPU fetch, post-reset clear sweep.
// Reads return one cycle after the strobe; write priority sweep > DMA > CPU, losers are dropped.
module lr35902_oam_banked
    import lr35902_oam_pkg::*;
#(
    parameter int ENTRIES         = OAM_ENTRIES,
    parameter int BYTES_PER_ENTRY = OAM_BYTES_PER_ENTRY,
    parameter int LANES           = OAM_LANES,
    parameter int ADR_W           = 8,
    localparam int BYTES  = ENTRIES * BYTES_PER_ENTRY,
    localparam int WORDS  = oam_words(ENTRIES, BYTES_PER_ENTRY, LANES),
    localparam int WADR_W = oam_wadr_w(ENTRIES, BYTES_PER_ENTRY, LANES)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [ADR_W-1:0]   cpu_adr,
    input  logic [7:0]         cpu_din,
    input  logic               cpu_rd,
    input  logic               cpu_wr,
    output logic [7:0]         cpu_dout,
    input  logic               lock,
    input  logic [ADR_W-1:0]   dma_adr,
    input  logic [7:0]         dma_din,
    input  logic               dma_wr,
    input  logic [WADR_W-1:0]  ppu_adr,
    input  logic               ppu_rd,
    output logic [8*LANES-1:0] ppu_dout,
    output logic               busy
);

    localparam int LANE_SH = $clog2(LANES);
    localparam int LSEL_W  = (LANES > 1) ? $clog2(LANES) : 1;

    logic              busy_q;
    logic [WADR_W-1:0] clr_cnt;
    logic              cpu_wr_q;
    logic              cpu_fill;
    logic [LSEL_W-1:0] cpu_sel;
    logic              ppu_zero;
    logic              ppu_oob;

    logic              cpu_in, dma_in, ppu_in;
    logic              dma_ok, cpu_commit;
    logic [WADR_W-1:0] cpu_word, dma_word;
    logic [LSEL_W-1:0] cpu_lane, dma_lane;

    oam_wsrc_t         wsrc;
    logic [WADR_W-1:0] wr_word;
    logic [LSEL_W-1:0] wr_lane;
    logic [7:0]        wr_dat;

    logic [7:0]         cpu_lane_dat [LANES];
    logic [7:0]         ppu_lane_dat [LANES];
    logic [8*LANES-1:0] ppu_word;

    // Range checks at full address width: nothing above BYTES aliases back into OAM.
    assign cpu_in = 32'(cpu_adr) < BYTES;
    assign dma_in = 32'(dma_adr) < BYTES;
    assign ppu_in = 32'(ppu_adr) < WORDS;

    assign cpu_word = WADR_W'(cpu_adr >> LANE_SH);
    assign dma_word = WADR_W'(dma_adr >> LANE_SH);
    assign cpu_lane = LSEL_W'(32'(cpu_adr) % LANES);
    assign dma_lane = LSEL_W'(32'(dma_adr) % LANES);

    assign dma_ok     = dma_wr && dma_in;
    assign cpu_commit = cpu_wr_q && !cpu_wr && !lock && cpu_in;

    always_comb begin
        wsrc    = WSRC_NONE;
        wr_word = '0;
        wr_lane = '0;
        wr_dat  = '0;
        if (reset) begin
            wsrc = WSRC_NONE;
        end else if (busy_q) begin
            wsrc    = WSRC_CLEAR;
            wr_word = clr_cnt;
        end else if (dma_ok) begin
            wsrc    = WSRC_DMA;
            wr_word = dma_word;
            wr_lane = dma_lane;
            wr_dat  = dma_din;
        end else if (cpu_commit) begin
            wsrc    = WSRC_CPU;
            wr_word = cpu_word;
            wr_lane = cpu_lane;
            wr_dat  = cpu_din;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            busy_q   <= 1'b1;
            clr_cnt  <= '0;
            cpu_wr_q <= 1'b0;
            cpu_fill <= 1'b1;
            cpu_sel  <= '0;
            ppu_zero <= 1'b1;
            ppu_oob  <= 1'b0;
        end else begin
            cpu_wr_q <= cpu_wr;
            if (busy_q) begin
                clr_cnt <= clr_cnt + WADR_W'(1);
                if (clr_cnt == WADR_W'(WORDS - 1)) busy_q <= 1'b0;
            end
            if (cpu_rd) begin
                cpu_fill <= lock || busy_q || !cpu_in;
                cpu_sel  <= cpu_lane;
            end
            if (ppu_rd) begin
                ppu_zero <= 1'b0;
                ppu_oob  <= !ppu_in;
            end
        end
    end

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        logic lane_we;
        assign lane_we = (wsrc == WSRC_CLEAR) ||
                         (((wsrc == WSRC_DMA) || (wsrc == WSRC_CPU)) && (wr_lane == LSEL_W'(i)));

        lr35902_oam_lane #(
            .WORDS  (WORDS),
            .WADR_W (WADR_W)
        ) u_lane (
            .clk   (clk),
            .we    (lane_we),
            .wadr  (wr_word),
            .wdat  (wr_dat),
            .a_rd  (cpu_rd && cpu_in && !reset),
            .a_adr (cpu_word),
            .a_dat (cpu_lane_dat[i]),
            .b_rd  (ppu_rd && ppu_in && !reset),
            .b_adr (ppu_adr),
            .b_dat (ppu_lane_dat[i])
        );

        assign ppu_word[8*i +: 8] = ppu_lane_dat[i];
    end

    assign cpu_dout = cpu_fill ? OAM_FILL_READ : cpu_lane_dat[cpu_sel];
    assign ppu_dout = ppu_zero ? '0 : (ppu_oob ? '1 : ppu_word);
    assign busy     = busy_q;

endmodule

// File: tb/tb_lr35902_oam_banked.sv
// Bench for lr35902_oam_banked: directed scenarios with literal expectations, then random traffic
// checked every cycle against a byte-array model of the OAM contents and sweep progress.
module tb_lr35902_oam_banked;

    localparam int BYTES = 160;
    localparam int WORDS = 80;
    localparam int L     = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  cpu_adr, cpu_din, dma_adr, dma_din;
    logic        cpu_rd, cpu_wr, lock, dma_wr, ppu_rd;
    logic [6:0]  ppu_adr;
    logic [7:0]  cpu_dout;
    logic [15:0] ppu_dout;
    logic        busy;

    int errors = 0;
    int checks = 0;

    lr35902_oam_banked dut (
        .clk      (clk),
        .reset    (reset),
        .cpu_adr  (cpu_adr),
        .cpu_din  (cpu_din),
        .cpu_rd   (cpu_rd),
        .cpu_wr   (cpu_wr),
        .cpu_dout (cpu_dout),
        .lock     (lock),
        .dma_adr  (dma_adr),
        .dma_din  (dma_din),
        .dma_wr   (dma_wr),
        .ppu_adr  (ppu_adr),
        .ppu_rd   (ppu_rd),
        .ppu_dout (ppu_dout),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: OAM as a flat byte array; the sweep is just "cycles left to clear".
    logic [7:0]  m_mem [BYTES];
    int          m_left;
    logic        m_prev_wr;
    logic        m_valid = 1'b0;
    logic        exp_busy;
    logic [7:0]  exp_cpu;
    logic [15:0] exp_ppu;

    always @(posedge clk) begin
        if (reset) begin
            m_valid   <= 1'b1;
            m_left    <= WORDS;
            m_prev_wr <= 1'b0;
            exp_busy  <= 1'b1;
            exp_cpu   <= 8'hFF;
            exp_ppu   <= 16'h0000;
        end else if (m_valid) begin
            automatic logic sweeping = (m_left > 0);
            if (cpu_rd)
                exp_cpu <= (lock || sweeping || cpu_adr >= BYTES) ? 8'hFF : m_mem[cpu_adr];
            if (ppu_rd) begin
                if (ppu_adr >= WORDS) exp_ppu <= 16'hFFFF;
                else for (int l = 0; l < L; l++) exp_ppu[8*l +: 8] <= m_mem[ppu_adr*L + l];
            end
            if (sweeping) begin
                for (int l = 0; l < L; l++) m_mem[(WORDS - m_left)*L + l] <= 8'h00;
                m_left <= m_left - 1;
            end else if (dma_wr && dma_adr < BYTES) begin
                m_mem[dma_adr] <= dma_din;
            end else if (m_prev_wr && !cpu_wr && !lock && cpu_adr < BYTES) begin
                m_mem[cpu_adr] <= cpu_din;
            end
            m_prev_wr <= cpu_wr;
            exp_busy  <= (m_left > 1) || (m_left == 1 && !sweeping);
        end
    end

    always @(negedge clk) begin
        if (m_valid) begin
            chk("busy", busy, exp_busy);
            chk("cpu_dout", cpu_dout, exp_cpu);
            chk("ppu_dout", ppu_dout, exp_ppu);
        end
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic ppu_read(input logic [6:0] a, input logic [15:0] exp, input string name);
        ppu_adr = a; ppu_rd = 1'b1;
        tick();
        ppu_rd = 1'b0;
        chk(name, ppu_dout, exp);
    endtask

    task automatic cpu_read(input logic [7:0] a, input logic [7:0] exp, input string name);
        cpu_adr = a; cpu_rd = 1'b1;
        tick();
        cpu_rd = 1'b0;
        chk(name, cpu_dout, exp);
    endtask

    task automatic cpu_write(input logic [7:0] a, input logic [7:0] d);
        cpu_adr = a; cpu_din = d; cpu_wr = 1'b1;
        tick();
        tick();
        cpu_wr = 1'b0;
        tick();
    endtask

    // Called at the edge of reset release; busy must read high for exactly WORDS samples.
    task automatic count_busy(input string name);
        int n = 0;
        while (busy === 1'b1 && n < 200) begin
            n++;
            tick();
        end
        chk(name, n, WORDS);
    endtask

    initial begin
        reset = 1'b1; cpu_adr = 0; cpu_din = 0; cpu_rd = 0; cpu_wr = 0; lock = 0;
        dma_adr = 0; dma_din = 0; dma_wr = 0; ppu_adr = 0; ppu_rd = 0;
        repeat (3) tick();
        chk("reset_busy", busy, 1'b1);
        chk("reset_cpu_dout", cpu_dout, 8'hFF);
        chk("reset_ppu_dout", ppu_dout, 16'h0000);
        reset = 1'b0;
        count_busy("sweep_len");
        for (int w = 0; w < WORDS; w++) ppu_read(7'(w), 16'h0000, "cleared_word");

        cpu_write(8'h05, 8'h9F);
        ppu_read(7'd2, 16'h9F00, "cpu_wr_ppu_w2");
        cpu_read(8'h05, 8'h9F, "cpu_rd_05");

        cpu_write(8'hA0, 8'h77);
        cpu_read(8'hA0, 8'hFF, "cpu_rd_oob");
        ppu_read(7'd80, 16'hFFFF, "ppu_rd_oob");

        lock = 1'b1;
        cpu_read(8'h05, 8'hFF, "locked_cpu_rd");
        ppu_adr = 7'd2; ppu_rd = 1'b1;
        cpu_write(8'h06, 8'h12);
        ppu_rd = 1'b0;
        chk("locked_ppu_rd", ppu_dout, 16'h9F00);
        lock = 1'b0;
        ppu_read(7'd3, 16'h0000, "locked_wr_dropped");

        cpu_adr = 8'h11; cpu_din = 8'hAA; cpu_wr = 1'b1;
        tick();
        cpu_wr = 1'b0; dma_adr = 8'h10; dma_din = 8'h55; dma_wr = 1'b1;
        tick();
        dma_wr = 1'b0;
        ppu_read(7'd8, 16'h0055, "dma_beats_cpu");

        dma_adr = 8'h20; dma_din = 8'h66; dma_wr = 1'b1;
        tick();
        dma_wr = 1'b0;
        ppu_read(7'd16, 16'h0066, "dma_w16");
        reset = 1'b1;
        tick();
        reset = 1'b0;
        repeat (10) tick();
        dma_adr = 8'h9E; dma_din = 8'h44; dma_wr = 1'b1;
        tick();
        dma_wr = 1'b0;
        ppu_read(7'd79, 16'h0000, "dma_during_busy");
        repeat (28) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        count_busy("sweep_restart_len");
        ppu_read(7'd16, 16'h0000, "dma_cleared_by_sweep");

        for (int i = 0; i < 3000; i++) begin
            reset   = ($urandom_range(0, 399) == 0);
            lock    = ($urandom_range(0, 3) == 0);
            cpu_rd  = $urandom_range(0, 1);
            cpu_wr  = ($urandom_range(0, 2) == 0);
            cpu_adr = 8'($urandom_range(0, 175));
            cpu_din = 8'($urandom);
            dma_wr  = ($urandom_range(0, 3) == 0);
            dma_adr = 8'($urandom_range(0, 175));
            dma_din = 8'($urandom);
            ppu_rd  = $urandom_range(0, 1);
            ppu_adr = 7'($urandom_range(0, 85));
            tick();
        end
        reset = 1'b0; cpu_rd = 0; cpu_wr = 0; dma_wr = 0; ppu_rd = 0; lock = 0;
        repeat (3) tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
